// File: rtl/uart_tx16_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx16_pkg
//
// Shared definitions for the 16-bit Hack word UART transmitter:
//   - tx_state_e           : transmitter FSM state encoding
//   - DEFAULT_CLKS_PER_BIT : 25 MHz / 115200 baud
//   - BITS_PER_BYTE        : data bits carried by each frame
//   - even_parity()        : parity bit that makes the count of ones even
//
// The PARITY state is part of the encoding in every build. It is only
// reachable when UART_TX16_PARITY_EN is defined.
// -----------------------------------------------------------------------------
package uart_tx16_pkg;

   localparam int unsigned DEFAULT_CLKS_PER_BIT = 217;
   localparam int unsigned BITS_PER_BYTE        = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   // XOR of the data bits. Sending this bit makes the total number of ones
   // in the data bits plus the parity bit even.
   function automatic logic even_parity(input logic [7:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
//
// Free-running bit-period counter. It emits a one-cycle tick on the last cycle
// of every CLKS_PER_BIT-cycle period, then wraps to 0. Because it wraps with no
// remainder, bit timing does not drift. The receive side can use the same
// block.
//
// Ports:
//   clk   in  1  system clock
//   rst_n in  1  asynchronous active-low reset (counter -> 0)
//   clr   in  1  synchronous clear: holds the counter at 0 and masks tick
//   tick  out 1  high on the final cycle of each bit period
// -----------------------------------------------------------------------------
module uart_baud_tick
   import uart_tx16_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   // A 16-bit counter covers the full legal range 2..65535.
   localparam logic [15:0] LAST_COUNT = 16'(CLKS_PER_BIT - 1);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr || (cnt_q == LAST_COUNT)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = !clr && (cnt_q == LAST_COUNT);

endmodule

// File: rtl/uart_tx16.sv
// -----------------------------------------------------------------------------
// uart_tx16
//
// Transmits a 16-bit Hack word as two back-to-back UART frames, low byte
// first. The default build sends 8N1 frames, so busy lasts 20*CLKS_PER_BIT
// cycles. If UART_TX16_PARITY_EN is defined, each frame is 8E1 and carries an
// even-parity bit after data bit 7, so busy lasts 22*CLKS_PER_BIT cycles.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (2..65535)
//   IDLE_LEVEL    line level while idle and during stop bits
//
// Ports:
//   clk    in  1   system clock
//   rst_n  in  1   asynchronous active-low reset; aborts any frame in flight
//   in     in  16  word to transmit; sampled only on an accepted load
//   load   in  1   transmit request; accepted only while busy=0
//   busy   out 1   high from the cycle after accept to the end of the last stop bit
//   tx     out 1   registered serial line
//   done   out 1   one-cycle pulse in the cycle busy falls
// -----------------------------------------------------------------------------
module uart_tx16
   import uart_tx16_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter logic        IDLE_LEVEL   = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] in,
   input  logic        load,
   output logic        busy,
   output logic        tx,
   output logic        done
);

   tx_state_e   state_q,    state_d;
   logic [2:0]  bit_cnt_q,  bit_cnt_d;
   logic        byte_sel_q, byte_sel_d;
   logic [15:0] hold_q,     hold_d;
   logic [7:0]  shift_q,    shift_d;
   logic        busy_q,     busy_d;
   logic        done_q,     done_d;
   logic        tx_q,       tx_d;

   logic        tick;
   logic        baud_clr;
   logic [7:0]  cur_byte;

   // Hold the baud counter at 0 while idle, so the first bit period after an
   // accept is a full CLKS_PER_BIT cycles long.
   assign baud_clr = (state_q == ST_IDLE);

   uart_baud_tick #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (baud_clr),
      .tick  (tick)
   );

   assign cur_byte = byte_sel_q ? hold_q[15:8] : hold_q[7:0];

   // tx is registered. Each transition loads the level of the *next* bit, so
   // the line changes on the same edge as the state.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      byte_sel_d = byte_sel_q;
      hold_d     = hold_q;
      shift_d    = shift_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      tx_d       = tx_q;

      case (state_q)
         ST_IDLE: begin
            tx_d = IDLE_LEVEL;
            if (load) begin
               hold_d     = in;
               byte_sel_d = 1'b0;
               bit_cnt_d  = 3'd0;
               busy_d     = 1'b1;
               tx_d       = ~IDLE_LEVEL;
               state_d    = ST_START;
            end
         end

         ST_START: begin
            if (tick) begin
               // Start bit ends: put out bit 0 and keep bits 7..1 in the
               // shifter for the DATA state.
               tx_d      = cur_byte[0];
               shift_d   = {1'b0, cur_byte[7:1]};
               bit_cnt_d = 3'd0;
               state_d   = ST_DATA;
            end
         end

         ST_DATA: begin
            // bit_cnt_q is the index of the data bit now on the line.
            if (tick) begin
               if (bit_cnt_q == 3'(BITS_PER_BYTE - 1)) begin
                  bit_cnt_d = 3'd0;
`ifdef UART_TX16_PARITY_EN
                  tx_d      = even_parity(cur_byte);
                  state_d   = ST_PARITY;
`else
                  tx_d      = IDLE_LEVEL;
                  state_d   = ST_STOP;
`endif
               end else begin
                  tx_d      = shift_q[0];
                  shift_d   = {1'b0, shift_q[7:1]};
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end

`ifdef UART_TX16_PARITY_EN
         ST_PARITY: begin
            if (tick) begin
               tx_d    = IDLE_LEVEL;
               state_d = ST_STOP;
            end
         end
`endif

         ST_STOP: begin
            if (tick) begin
               if (!byte_sel_q) begin
                  // Go straight into the high byte's start bit. There is no
                  // idle gap between the two frames.
                  byte_sel_d = 1'b1;
                  tx_d       = ~IDLE_LEVEL;
                  state_d    = ST_START;
               end else begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  tx_d    = IDLE_LEVEL;
                  state_d = ST_IDLE;
               end
            end
         end

         default: begin
            busy_d  = 1'b0;
            tx_d    = IDLE_LEVEL;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= 3'd0;
         byte_sel_q <= 1'b0;
         hold_q     <= '0;
         shift_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         tx_q       <= IDLE_LEVEL;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_sel_q <= byte_sel_d;
         hold_q     <= hold_d;
         shift_q    <= shift_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         tx_q       <= tx_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign tx   = tx_q;

endmodule

// File: doc/uart_tx16.md
Name: uart_tx16

Overview:
- Serial transmitter for 16-bit Hack words.
- Takes a parallel word from the CPU memory-mapped I/O path and shifts it out on a single UART line as two 8N1 frames: low byte first, then high byte.
- Outbound counterpart of the word-receive path; sits between the Hack memory-mapped register and the board TX pin.

Parameters:
- CLKS_PER_BIT, 217, clock cycles per UART bit (25 MHz / 115200 baud); legal range 2..65535.
- IDLE_LEVEL, 1'b1, line level while idle and during stop bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in  input  16  word to transmit; sampled only on an accepted load.
- load  input  1  request to transmit `in`; accepted only when busy=0.
- busy  output  1  high from the cycle after an accepted load until the last stop bit completes.
- tx  output  1  serial line, registered output.
- done  output  1  single-cycle pulse in the cycle busy falls.

Behaviour:
- Clock and reset: one clock, `clk`. Reset is asynchronous and active-low on `rst_n`.
- Reset values: tx=IDLE_LEVEL, busy=0, done=0, state=IDLE, bit counter=0, baud counter=0, byte select=0, shift register=0.
- Reset asserted mid-frame aborts immediately: tx returns to idle level asynchronously and no partial-frame recovery is attempted.
- Accept rule: load=1 && busy=0 at a clock edge latches `in` into a 16-bit holding register.
  - busy=1 from the next cycle.
  - load while busy=1 is ignored; no queueing, the word is dropped.
- States: IDLE -> START -> DATA -> STOP -> (START for the high byte | IDLE).
  - IDLE: tx=IDLE_LEVEL. On accept: byte select=0, go to START.
  - START: tx=~IDLE_LEVEL for CLKS_PER_BIT cycles.
  - DATA: 8 bits of the selected byte, LSB first, each held exactly CLKS_PER_BIT cycles. The bit counter runs 0..7.
  - STOP: tx=IDLE_LEVEL for CLKS_PER_BIT cycles.
    - If byte select=0: set it to 1 and go to START with no extra idle gap.
    - Otherwise go to IDLE, busy=0, done=1 for one cycle.
- Latency: the tx start edge appears 1 cycle after the accepting edge.
- Total busy time is exactly 20*CLKS_PER_BIT cycles (2 × 10 bits).
- The baud counter reloads to 0 at every bit boundary; the count is exact with no accumulated drift.
- Back-to-back transfers: load may be asserted in the same cycle done=1 (busy already 0) and is accepted. The next start bit follows 1 cycle later.
- Word 16'h0000 and 16'hFFFF need no special handling.

Optional Feature:
- Macro: UART_TX16_PARITY_EN.
- Defined: each frame becomes 8E1 — an even-parity bit (XOR of the 8 data bits) is sent after bit 7, adding a PARITY state between DATA and STOP. Busy time becomes 22*CLKS_PER_BIT cycles.
- Undefined: 8N1 exactly as above; no PARITY state or logic is present.

Decomposition:
- Shared package/include: state encodings (ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP) and default CLKS_PER_BIT.
- One sub-module: uart_baud_tick (counter emitting a one-cycle tick every CLKS_PER_BIT cycles, synchronous clear input). It is reusable by the receive side.

Test Plan:
- Reset: rst_n=0 for 3 cycles, then release -> tx=1, busy=0, done=0, and tx stays 1 for 100 cycles with load=0.
- Single word, CLKS_PER_BIT=4: load in=16'hA53C for 1 cycle.
  - Decoded line bits are 0,00111100(LSB-first of 8'h3C),1,0,10100101(LSB-first of 8'hA5),1.
  - busy high exactly 80 cycles; done pulses once.
- Load while busy: during the transfer of 16'h1234, pulse load with in=16'hFFFF -> line carries only 16'h1234 and busy length is unchanged.
- Back-to-back: assert load with 16'h00FF in the done cycle of the prior word -> start bit begins 1 cycle later, and both words decode correctly.
- Mid-frame reset: assert rst_n=0 at cycle 30 of a transfer -> tx=1 and busy=0 without waiting for a clock edge. A subsequent load of 16'h5555 transmits cleanly.
- With UART_TX16_PARITY_EN defined: in=16'h0301 -> parity bits are 1 (low byte 8'h01) and 0 (high byte 8'h03); busy is 88 cycles at CLKS_PER_BIT=4.
